// File: rtl/nibble_serial_subtractor.sv
// Wide subtractor built from one 4-bit borrow-chained slice.
// Sequences NIBBLES slice passes, LS nibble first, behind start/busy/done.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module nibble_serial_subtractor #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] Diff,
   output logic                 Borrow,
   output logic                 Zero,
   output logic                 Ovf
);
   localparam int W = 4 * NIBBLES;
   localparam logic [3:0] LAST = 4'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   work_q, work_d;
   logic           brw_q, brw_d;
   logic [3:0]     idx_q, idx_d;
   logic           amsb_q, amsb_d;
   logic           bmsb_q, bmsb_d;
   logic [W-1:0]   diff_q, diff_d;
   logic           bout_q, bout_d;
   logic           zero_q, zero_d;
   logic           ovf_q, ovf_d;

   logic [4:0]     chain;
   logic [3:0]     nib;
   logic [W+3:0]   shifted;
   logic [W-1:0]   work_nx;

   assign chain[0] = brw_q;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_slice
         full_subtractor u_fs (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .bi (chain[i]),
            .d  (nib[i]),
            .bo (chain[i+1])
         );
      end
   endgenerate

   assign shifted = {nib, work_q};
   assign work_nx = shifted[W+3:4];

   // Next-state logic: accept, step one nibble per cycle, publish result.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      brw_d   = brw_q;
      idx_d   = idx_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               work_d  = '0;
               brw_d   = 1'b0;
               idx_d   = 4'd0;
               amsb_d  = A[W-1];
               bmsb_d  = B[W-1];
               state_d = RUN;
            end
         end
         RUN: begin
            a_d    = a_q >> 4;
            b_d    = b_q >> 4;
            work_d = work_nx;
            brw_d  = chain[4];
            idx_d  = idx_q + 4'd1;
            if (idx_q == LAST) begin
               state_d = DONE;
               diff_d  = work_nx;
               bout_d  = chain[4];
               zero_d  = (work_nx == '0);
               ovf_d   = (amsb_q != bmsb_q) &&
                         (work_nx[W-1] != amsb_q);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         brw_q   <= 1'b0;
         idx_q   <= 4'd0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         brw_q   <= brw_d;
         idx_q   <= idx_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign Diff   = diff_q;
   assign Borrow = bout_q;
   assign Zero   = zero_q;
   assign Ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (NIBBLES=4).
// Stimulus pushes expected results; monitor pops on done.

module tb_nibble_serial_subtractor;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        busy, done, Borrow, Zero, Ovf;
   logic [15:0] Diff;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [15:0] d;
      logic        b;
      logic        z;
      logic        o;
   } exp_t;

   exp_t sb[$];
   exp_t last;

   nibble_serial_subtractor #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .Diff   (Diff),
      .Borrow (Borrow),
      .Zero   (Zero),
      .Ovf    (Ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Monitor: compare each done pulse against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy_done_excl", 32'(busy & done), 32'd0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("Diff", 32'(Diff), 32'(e.d));
               chk("Borrow", 32'(Borrow), 32'(e.b));
               chk("Zero", 32'(Zero), 32'(e.z));
               chk("Ovf", 32'(Ovf), 32'(e.o));
            end
         end
      end
   end

   task automatic push(input logic [15:0] d, input logic b,
                       input logic z, input logic o);
      exp_t e;
      e.d = d; e.b = b; e.z = z; e.o = o;
      sb.push_back(e);
      last = e;
   endtask

   task automatic wait_level(input logic which_done, input logic lvl,
                             input string name);
      int n;
      n = 0;
      while (((which_done ? done : busy) !== lvl) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30) chk(name, 32'd0, 32'd1);
   endtask

   task automatic op(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] d, input logic bw,
                     input logic z, input logic o);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      push(d, bw, z, o);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      A = ~a; B = ~b;
      wait_level(1'b1, 1'b1, "done_timeout");
      @(negedge clk);
   endtask

   initial begin
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_Diff", 32'(Diff), 32'd0);
      chk("rst_flags", 32'({Borrow, Zero, Ovf}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Latency: busy for 4 cycles then done for one.
      @(negedge clk);
      A = 16'h1234; B = 16'h0234; start = 1'b1;
      push(16'h1000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("lat_busy", 32'({busy, done}), 32'b10);
         @(negedge clk);
      end
      chk("lat_done", 32'({busy, done}), 32'b01);
      @(negedge clk);
      chk("lat_idle", 32'({busy, done}), 32'b00);

      op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0);
      op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      op(16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1, 1'b0);
      op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1);

      // Outputs hold while idle, even with new inputs present.
      A = 16'h1111; B = 16'h2222;
      repeat (3) @(negedge clk);
      chk("hold_Diff", 32'(Diff), 32'(last.d));
      chk("hold_flags", 32'({Borrow, Zero, Ovf}),
          32'({last.b, last.z, last.o}));

      // Start held high; operands change while RUN.
      @(negedge clk);
      A = 16'h5555; B = 16'h1111; start = 1'b1;
      push(16'h4444, 1'b0, 1'b0, 1'b0);
      wait_level(1'b0, 1'b1, "held_acc0");
      repeat (2) @(negedge clk);
      A = 16'h0100; B = 16'h0200;
      push(16'hFF00, 1'b1, 1'b0, 1'b0);
      wait_level(1'b0, 1'b0, "held_end0");
      wait_level(1'b0, 1'b1, "held_acc1");
      repeat (2) @(negedge clk);
      A = 16'h9000; B = 16'h1000;
      push(16'h8000, 1'b0, 1'b0, 1'b0);
      wait_level(1'b0, 1'b0, "held_end1");
      wait_level(1'b0, 1'b1, "held_acc2");
      start = 1'b0;
      A = 16'hFFFF; B = 16'hFFFF;
      wait_level(1'b1, 1'b1, "held_done2");
      repeat (3) @(negedge clk);
      chk("held_idle", 32'(busy), 32'd0);

      // Reset mid-operation after two nibbles.
      @(negedge clk);
      A = 16'h1234; B = 16'h1111; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'({busy, done}), 32'd0);
      chk("mid_rst_Diff", 32'(Diff), 32'd0);
      chk("mid_rst_flags", 32'({Borrow, Zero, Ovf}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
